// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - sequential shift-add multiplier with signed/unsigned modes and early termination
module seq_mult_unit #(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p_out,
    output logic                 zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 sign_q;

    logic                 signed_act;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Signed handling only exists when the parameter enables it.
    assign signed_act = SIGNED_EN && signed_mode;

    // Absolute values; the most-negative code maps to 2^(WIDTH-1) as an unsigned value.
    assign a_mag = (signed_act && a_in[WIDTH-1]) ? -a_in : a_in;
    assign b_mag = (signed_act && b_in[WIDTH-1]) ? -b_in : b_in;

    assign zero = (b_q == '0);

    // Controller and datapath; busy/done are registered copies of the state decode, trailing it by one clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            sign_q <= 1'b0;
            p_out  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= {{WIDTH{1'b0}}, a_mag};
                        b_q    <= b_mag;
                        p_q    <= '0;
                        sign_q <= signed_act && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (b_q != '0) begin
                        if (b_q[0]) begin
                            p_q <= p_q + a_q;
                        end
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end else begin
                        p_out <= sign_q ? -p_q : p_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - directed table-driven bench for seq_mult_unit
module tb_seq_mult_unit;

    logic        clk;
    logic        clr_n;

    logic        start4;
    logic        sm4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;
    logic        zero4;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;
    logic        zero8;

    int n_checks;
    int n_pass;

    seq_mult_unit #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .clr_n(clr_n), .start(start4), .signed_mode(sm4),
        .a_in(a4), .b_in(b4), .busy(busy4), .done(done4), .p_out(p4), .zero(zero4)
    );

    seq_mult_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .signed_mode(sm8),
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .p_out(p8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         done_edge;
        int         busy_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start a WIDTH=4 multiply at edge 0 and report done edge and number of busy cycles.
    task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                        output int de, output int bc);
        de = -1;
        bc = 0;
        @(negedge clk);
        start4 = 1'b1;
        sm4    = sm;
        a4     = a;
        b4     = b;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (busy4) bc++;
            if (done4) begin
                de = e;
                break;
            end
        end
    endtask

    initial begin
        int de;
        int bc;
        int dcount;

        n_checks = 0;
        n_pass   = 0;
        clr_n  = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;

        vecs[0] = '{"u_2x3",  1'b0, 4'h2, 4'h3, 8'h06, 4, 3};
        vecs[1] = '{"u_5x0",  1'b0, 4'h5, 4'h0, 8'h00, 2, 1};
        vecs[2] = '{"s_Dx5",  1'b1, 4'hD, 4'h5, 8'hF1, 5, 4};
        vecs[3] = '{"s_8x8",  1'b1, 4'h8, 4'h8, 8'h40, 6, 5};
        vecs[4] = '{"u_FxF",  1'b0, 4'hF, 4'hF, 8'hE1, 6, 5};
        vecs[5] = '{"s_7xF",  1'b1, 4'h7, 4'hF, 8'hF9, 3, 2};
        vecs[6] = '{"u_Dx5",  1'b0, 4'hD, 4'h5, 8'h41, 5, 4};

        #1;
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_p",    {24'd0, p4},    32'd0);
        chk("rst_zero", {31'd0, zero4}, 32'd1);
        chk("rst_p8",   {16'd0, p8},    32'd0);

        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run4(vecs[i].sm, vecs[i].a, vecs[i].b, de, bc);
            chk({vecs[i].name, "_p"},    {24'd0, p4}, {24'd0, vecs[i].p});
            chk({vecs[i].name, "_edge"}, de, vecs[i].done_edge);
            chk({vecs[i].name, "_busy"}, bc, vecs[i].busy_cyc);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_done_1cyc"}, {31'd0, done4}, 32'd0);
        end

        // b = 0 keeps zero asserted from the start edge through RUN
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'h5; b4 = 4'h0;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("zero_run_e0", {31'd0, zero4}, 32'd1);
        @(posedge clk);
        #1;
        chk("zero_run_e1", {31'd0, zero4}, 32'd1);
        chk("busy_b0_e1",  {31'd0, busy4}, 32'd1);
        repeat (3) @(posedge clk);

        // start during RUN with new operands is ignored
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'h2; b4 = 4'h3;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        #1;
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; sm4 = 1'b1;
        de = -1;
        for (int e = 2; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) start4 = 1'b0;
            if (done4) begin
                de = e;
                break;
            end
        end
        chk("ign_start_p",    {24'd0, p4}, 32'h06);
        chk("ign_start_edge", de, 4);
        repeat (4) @(posedge clk);
        #1;
        chk("ign_start_idle", {31'd0, busy4}, 32'd0);

        // reset mid-RUN: outputs clear at once and no done follows
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_busy_before", {31'd0, busy4}, 32'd1);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy4}, 32'd0);
        chk("mid_rst_done", {31'd0, done4}, 32'd0);
        chk("mid_rst_p",    {24'd0, p4},    32'd0);
        chk("mid_rst_zero", {31'd0, zero4}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        dcount = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        chk("mid_rst_p_after", {24'd0, p4}, 32'd0);

        // first edge after reset release accepts start
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'h3; b4 = 4'h3;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        de = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                de = e;
                break;
            end
        end
        chk("post_rst_p",    {24'd0, p4}, 32'h09);
        chk("post_rst_edge", de, 4);

        // WIDTH=8 with signed support disabled: signed_mode ignored
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        de = -1;
        bc = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (busy8) bc++;
            if (done8) begin
                de = e;
                break;
            end
        end
        chk("w8_p",    {16'd0, p8}, 32'hFE01);
        chk("w8_edge", de, 10);
        chk("w8_busy", bc, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
